// File: rtl/id_ex_stage.sv
// ID->EX operand stage: RAW forwarding (EX > MEM > WB > regfile), load-use detection and the ID/EX register.
// Build option ID_EX_BYPASS_EN enables forwarding; without it every RAW stalls until the regfile holds the value.
module id_ex_stage #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic              cpu_clk,
   input  logic              cpu_rst,
   input  logic              flush,
   input  logic              ex_hold,
   input  logic              id_valid,
   input  logic [XLEN-1:0]   id_pc,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic [XLEN-1:0]   id_rd1,
   input  logic [XLEN-1:0]   id_rd2,
   input  logic [XLEN-1:0]   id_imm,
   input  logic [8:0]        id_ctrl,
   input  logic [XLEN-1:0]   ex_alu_out,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic              mem_we,
   input  logic [XLEN-1:0]   mem_wdata,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic              wb_we,
   input  logic [XLEN-1:0]   wb_wdata,
   output logic              id_stall,
   output logic              ex_valid,
   output logic [XLEN-1:0]   ex_pc,
   output logic [XLEN-1:0]   ex_alu_a,
   output logic [XLEN-1:0]   ex_alu_b,
   output logic [6:0]        ex_ctrl,
   output logic [REG_AW-1:0] ex_rd,
   output logic [XLEN-1:0]   ex_store_data
);

   logic ex_is_load;
   logic ex_rf_we;
   logic id_asel;
   logic id_bsel;
   logic rs1_nz;
   logic rs2_nz;
   logic ex_m1, ex_m2;
   logic mem_m1, mem_m2;
   logic wb_m1, wb_m2;
   logic hazard;
   logic [XLEN-1:0] fwd1;
   logic [XLEN-1:0] fwd2;
   logic [XLEN-1:0] alu_a_d;
   logic [XLEN-1:0] alu_b_d;

   assign ex_is_load = ex_ctrl[6];
   assign ex_rf_we   = ex_ctrl[5];
   assign id_asel    = id_ctrl[8];
   assign id_bsel    = id_ctrl[7];

   // x0 is hardwired, so a zero source index never matches any producer
   assign rs1_nz = (id_rs1 != '0);
   assign rs2_nz = (id_rs2 != '0);

   assign ex_m1  = ex_valid & ex_rf_we & (ex_rd == id_rs1) & rs1_nz;
   assign ex_m2  = ex_valid & ex_rf_we & (ex_rd == id_rs2) & rs2_nz;
   assign mem_m1 = mem_we & (mem_rd == id_rs1) & rs1_nz;
   assign mem_m2 = mem_we & (mem_rd == id_rs2) & rs2_nz;
   assign wb_m1  = wb_we & (wb_rd == id_rs1) & rs1_nz;
   assign wb_m2  = wb_we & (wb_rd == id_rs2) & rs2_nz;

`ifdef ID_EX_BYPASS_EN
   always_comb begin
      fwd1 = id_rd1;
      if (ex_m1)       fwd1 = ex_alu_out;
      else if (mem_m1) fwd1 = mem_wdata;
      else if (wb_m1)  fwd1 = wb_wdata;
   end

   always_comb begin
      fwd2 = id_rd2;
      if (ex_m2)       fwd2 = ex_alu_out;
      else if (mem_m2) fwd2 = mem_wdata;
      else if (wb_m2)  fwd2 = wb_wdata;
   end

   // Only a load in EX has no result yet; one bubble lets MEM supply it
   assign hazard = id_valid & (ex_m1 | ex_m2) & ex_is_load;
`else
   logic unused_bypass;
   assign unused_bypass = ^{ex_alu_out, mem_wdata, wb_wdata};

   assign fwd1 = id_rd1;
   assign fwd2 = id_rd2;

   // Wait until the producer has retired from WB and the regfile read is current
   assign hazard = id_valid & (ex_m1 | ex_m2 | mem_m1 | mem_m2 | wb_m1 | wb_m2);
`endif

   assign alu_a_d = id_asel ? id_pc  : fwd1;
   assign alu_b_d = id_bsel ? id_imm : fwd2;

   assign id_stall = (hazard | ex_hold) & ~flush & ~cpu_rst;

   // ID -> EX register: reset/flush/hazard insert a zeroed bubble, ex_hold freezes
   always_ff @(posedge cpu_clk) begin
      if (cpu_rst || flush || (!ex_hold && hazard)) begin
         ex_valid      <= 1'b0;
         ex_pc         <= '0;
         ex_alu_a      <= '0;
         ex_alu_b      <= '0;
         ex_ctrl       <= '0;
         ex_rd         <= '0;
         ex_store_data <= '0;
      end else if (!ex_hold) begin
         ex_valid      <= id_valid;
         ex_pc         <= id_pc;
         ex_alu_a      <= alu_a_d;
         ex_alu_b      <= alu_b_d;
         ex_ctrl       <= {id_ctrl[6] & id_valid, id_ctrl[5] & id_valid, id_ctrl[4:0]};
         ex_rd         <= id_rd;
         ex_store_data <= fwd2;
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; the forwarding or stall-only scenarios follow the ID_EX_BYPASS_EN build.
module tb_id_ex_stage;

   logic        cpu_clk = 1'b0;
   logic        cpu_rst;
   logic        flush;
   logic        ex_hold;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic [4:0]  id_rd;
   logic [31:0] id_rd1;
   logic [31:0] id_rd2;
   logic [31:0] id_imm;
   logic [8:0]  id_ctrl;
   logic [31:0] ex_alu_out;
   logic [4:0]  mem_rd;
   logic        mem_we;
   logic [31:0] mem_wdata;
   logic [4:0]  wb_rd;
   logic        wb_we;
   logic [31:0] wb_wdata;
   logic        id_stall;
   logic        ex_valid;
   logic [31:0] ex_pc;
   logic [31:0] ex_alu_a;
   logic [31:0] ex_alu_b;
   logic [6:0]  ex_ctrl;
   logic [4:0]  ex_rd;
   logic [31:0] ex_store_data;

   int tests  = 0;
   int failed = 0;

   // {asel,bsel,is_load,rf_we,unsigned_sel,alu_sel}
   localparam logic [8:0] CTRL_ALU   = 9'b0_0_0_1_0_0000;
   localparam logic [8:0] CTRL_SUB   = 9'b0_0_0_1_0_1000;
   localparam logic [8:0] CTRL_LOAD  = 9'b0_1_1_1_0_0000;
   localparam logic [8:0] CTRL_STORE = 9'b0_1_0_0_1_0010;
   localparam logic [8:0] CTRL_PCIMM = 9'b1_1_0_1_0_0000;
   localparam logic [8:0] CTRL_LDX   = 9'b0_0_1_1_0_0101;

   id_ex_stage #(.XLEN(32), .REG_AW(5)) dut (
      .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .flush(flush), .ex_hold(ex_hold),
      .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rd(id_rd), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
      .id_ctrl(id_ctrl), .ex_alu_out(ex_alu_out), .mem_rd(mem_rd),
      .mem_we(mem_we), .mem_wdata(mem_wdata), .wb_rd(wb_rd), .wb_we(wb_we),
      .wb_wdata(wb_wdata), .id_stall(id_stall), .ex_valid(ex_valid),
      .ex_pc(ex_pc), .ex_alu_a(ex_alu_a), .ex_alu_b(ex_alu_b),
      .ex_ctrl(ex_ctrl), .ex_rd(ex_rd), .ex_store_data(ex_store_data)
   );

   always #5 cpu_clk = ~cpu_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] r1,
                        input logic [4:0] r2, input logic [4:0] rd, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] imm, input logic [8:0] c);
      id_valid = v;  id_pc = pc;  id_rs1 = r1; id_rs2 = r2; id_rd = rd;
      id_rd1   = d1; id_rd2 = d2; id_imm = imm; id_ctrl = c;
   endtask

   task automatic clr_fwd();
      ex_alu_out = 32'h0;
      mem_rd = 5'd0; mem_we = 1'b0; mem_wdata = 32'h0;
      wb_rd  = 5'd0; wb_we  = 1'b0; wb_wdata  = 32'h0;
   endtask

   task automatic tick();
      @(posedge cpu_clk);
      #1;
   endtask

   initial begin
      cpu_rst = 1'b1; flush = 1'b0; ex_hold = 1'b0;
      clr_fwd();
      drive(1'b1, 32'hFFFF_FFF0, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3, CTRL_LOAD);
      tick(); tick();
      check("rst_valid", 32'(ex_valid), 32'h0);
      check("rst_pc",    ex_pc,         32'h0);
      check("rst_a",     ex_alu_a,      32'h0);
      check("rst_ctrl",  32'(ex_ctrl),  32'h0);
      check("rst_store", ex_store_data, 32'h0);
      cpu_rst = 1'b0;

      // plain store-type instr: A from rs1, B from imm, store data from rs2
      drive(1'b1, 32'h100, 5'd1, 5'd2, 5'd0, 32'h11, 32'h22, 32'h44, CTRL_STORE);
      #1 check("basic_stall", 32'(id_stall), 32'h0);
      tick();
      check("basic_valid", 32'(ex_valid), 32'h1);
      check("basic_pc",    ex_pc,         32'h100);
      check("basic_a",     ex_alu_a,      32'h11);
      check("basic_b",     ex_alu_b,      32'h44);
      check("basic_store", ex_store_data, 32'h22);
      check("basic_ctrl",  32'(ex_ctrl),  32'h12);

      drive(1'b1, 32'h200, 5'd1, 5'd2, 5'd6, 32'h11, 32'h22, 32'h8, CTRL_PCIMM);
      tick();
      check("pcimm_a",    ex_alu_a,     32'h200);
      check("pcimm_b",    ex_alu_b,     32'h8);
      check("pcimm_ctrl", 32'(ex_ctrl), 32'h20);
      check("pcimm_rd",   32'(ex_rd),   32'h6);

      // invalid ID instr matching EX rd=6: no stall, is_load/rf_we gated off
      drive(1'b0, 32'h300, 5'd6, 5'd0, 5'd9, 32'h0, 32'h0, 32'h0, CTRL_LDX);
      #1 check("inv_stall", 32'(id_stall), 32'h0);
      tick();
      check("inv_valid", 32'(ex_valid), 32'h0);
      check("inv_ctrl",  32'(ex_ctrl),  32'h05);

`ifdef ID_EX_BYPASS_EN
      // EX forward beats a simultaneous MEM match
      drive(1'b1, 32'h400, 5'd0, 5'd0, 5'd5, 32'h0, 32'h0, 32'h0, CTRL_ALU);
      tick();
      drive(1'b1, 32'h404, 5'd5, 5'd0, 5'd0, 32'hDEAD, 32'h0, 32'h0, CTRL_STORE);
      ex_alu_out = 32'h10; mem_rd = 5'd5; mem_we = 1'b1; mem_wdata = 32'h77;
      #1 check("t1_stall", 32'(id_stall), 32'h0);
      tick();
      check("t1_a", ex_alu_a, 32'h10);
      clr_fwd();

      // load-use: one bubble, then the load value arrives from MEM
      drive(1'b1, 32'h408, 5'd0, 5'd0, 5'd7, 32'h0, 32'h0, 32'h0, CTRL_LOAD);
      tick();
      drive(1'b1, 32'h40C, 5'd0, 5'd7, 5'd8, 32'h0, 32'hEE, 32'h0, CTRL_ALU);
      #1 check("t2_stall", 32'(id_stall), 32'h1);
      tick();
      check("t2_bubble", 32'(ex_valid), 32'h0);
      mem_rd = 5'd7; mem_we = 1'b1; mem_wdata = 32'h55;
      #1 check("t2_stall_gone", 32'(id_stall), 32'h0);
      tick();
      check("t2_b",     ex_alu_b,      32'h55);
      check("t2_store", ex_store_data, 32'h55);
      check("t2_valid", 32'(ex_valid), 32'h1);
      clr_fwd();

      // x0 never forwards
      drive(1'b1, 32'h410, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, CTRL_ALU);
      tick();
      drive(1'b1, 32'h414, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, CTRL_ALU);
      ex_alu_out = 32'h99;
      #1 check("t3_stall", 32'(id_stall), 32'h0);
      tick();
      check("t3_a", ex_alu_a, 32'h0);
      clr_fwd();

      // MEM beats WB
      drive(1'b1, 32'h418, 5'd9, 5'd0, 5'd0, 32'h3, 32'h0, 32'h0, CTRL_ALU);
      mem_rd = 5'd9; mem_we = 1'b1; mem_wdata = 32'h1;
      wb_rd  = 5'd9; wb_we  = 1'b1; wb_wdata  = 32'h2;
      tick();
      check("t4_a", ex_alu_a, 32'h1);
      clr_fwd();
`else
      // add x3 then sub x4,x3: stall through EX, MEM and WB occupancy
      drive(1'b1, 32'h600, 5'd1, 5'd2, 5'd3, 32'h0, 32'h0, 32'h0, CTRL_ALU);
      tick();
      drive(1'b1, 32'h604, 5'd3, 5'd4, 5'd4, 32'h111, 32'h44, 32'h0, CTRL_SUB);
      ex_alu_out = 32'hBAD;
      for (int i = 0; i < 3; i++) begin
         mem_we = (i == 1); mem_rd = 5'd3; mem_wdata = 32'hBAD2;
         wb_we  = (i == 2); wb_rd  = 5'd3; wb_wdata  = 32'hBAD3;
         #1 check($sformatf("n1_stall%0d", i), 32'(id_stall), 32'h1);
         tick();
         check($sformatf("n1_bubble%0d", i), 32'(ex_valid), 32'h0);
      end
      clr_fwd();
      id_rd1 = 32'h333;
      #1 check("n1_release", 32'(id_stall), 32'h0);
      tick();
      check("n1_a",     ex_alu_a,     32'h333);
      check("n1_b",     ex_alu_b,     32'h44);
      check("n1_ctrl",  32'(ex_ctrl), 32'h28);
      check("n1_valid", 32'(ex_valid), 32'h1);

      // x0 never causes a RAW stall
      drive(1'b1, 32'h608, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, CTRL_ALU);
      tick();
      mem_rd = 5'd0; mem_we = 1'b1;
      #1 check("n2_stall", 32'(id_stall), 32'h0);
      tick();
      check("n2_a", ex_alu_a, 32'h0);
      clr_fwd();
`endif

      // load-type RAW with flush: flush wins, bubble, no stall
      drive(1'b1, 32'h700, 5'd0, 5'd0, 5'd7, 32'h0, 32'h0, 32'h0, CTRL_LOAD);
      tick();
      drive(1'b1, 32'h704, 5'd7, 5'd0, 5'd1, 32'hAB, 32'h0, 32'h0, CTRL_ALU);
      flush = 1'b1;
      #1 check("flush_stall", 32'(id_stall), 32'h0);
      tick();
      check("flush_valid", 32'(ex_valid), 32'h0);
      check("flush_a",     ex_alu_a,      32'h0);
      check("flush_ctrl",  32'(ex_ctrl),  32'h0);
      flush = 1'b0;

      // ex_hold freezes EX for 3 cycles while ID changes
      drive(1'b1, 32'h800, 5'd0, 5'd0, 5'd0, 32'hA1, 32'h0, 32'h0, CTRL_ALU);
      tick();
      ex_hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h900 + 32'(i), 5'd1, 5'd2, 5'd3, 32'hF0 + 32'(i), 32'h1, 32'h2, CTRL_PCIMM);
         #1 check($sformatf("hold_stall%0d", i), 32'(id_stall), 32'h1);
         tick();
         check($sformatf("hold_pc%0d", i), ex_pc,    32'h800);
         check($sformatf("hold_a%0d", i),  ex_alu_a, 32'hA1);
      end
      flush = 1'b1;
      #1 check("fh_stall", 32'(id_stall), 32'h0);
      tick();
      check("fh_valid", 32'(ex_valid), 32'h0);
      check("fh_pc",    ex_pc,         32'h0);
      flush = 1'b0; ex_hold = 1'b0;

      // reset during a RAW stall drops it and leaves a bubble
      drive(1'b1, 32'hA00, 5'd0, 5'd0, 5'd7, 32'h0, 32'h0, 32'h0, CTRL_LOAD);
      tick();
      drive(1'b1, 32'hA04, 5'd7, 5'd0, 5'd1, 32'h0, 32'h0, 32'h0, CTRL_ALU);
      #1 check("rs_stall", 32'(id_stall), 32'h1);
      cpu_rst = 1'b1;
      #1 check("rs_stall_rst", 32'(id_stall), 32'h0);
      tick();
      check("rs_valid", 32'(ex_valid), 32'h0);
      check("rs_ctrl",  32'(ex_ctrl),  32'h0);
      cpu_rst = 1'b0;
      #1 check("rs_after", 32'(id_stall), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
